// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer.
// State codes and default timing parameters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } sw_state_t;

    localparam int DB_DIV_DEF     = 1048576;
    localparam int DB_LEN_DEF     = 5;
    localparam int LONG_TICKS_DEF = 100;

endpackage

// File: rtl/sw_debounce.sv
// Button conditioner: synchronizer, tick-sampled window,
// hysteresis level and one-cycle rising-edge press pulse.
module sw_debounce #(
    parameter int DB_LEN = 5
) (
    input  logic clk0,
    input  logic reset_n,
    input  logic tick,
    input  logic sw,
    output logic level,
    output logic press
);

    logic [1:0]        sync_q;
    logic [DB_LEN-1:0] samp_q;
    logic              level_q;
    logic              level_d_q;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sw};
        end
    end

    // Shift one synchronized sample in per debounce tick
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '0;
        end else if (tick) begin
            samp_q <= {samp_q[DB_LEN-2:0], sync_q[1]};
        end
    end

    // Level changes only on a unanimous window, else holds
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
        end else begin
            level_d_q <= level_q;
            if (&samp_q) begin
                level_q <= 1'b1;
            end else if (~|samp_q) begin
                level_q <= 1'b0;
            end
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_d_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap sequencer for the 4-digit stopwatch datapath.
// Debounces buttons, drives count enable, clear and freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_DIV     = DB_DIV_DEF,
    parameter int DB_LEN     = DB_LEN_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF
) (
    input  logic       clk0,
    input  logic       reset_n,
    input  logic       start_sw,
    input  logic       lap_sw,
    input  logic       ovf_in,
    output logic       run,
    output logic       clr,
    output logic       freeze,
    output logic       ovf,
    output logic [1:0] state
);

    localparam int DIV_W = $clog2(DB_DIV);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             start_press;
    logic             start_lvl_unused;
    logic             lap_press;
    logic             lap_lvl;
    logic [7:0]       lp_cnt_q;
    logic             lp_fire;
    sw_state_t        st_q;
    logic             ovf_q;
    logic             clr_q;

    // Free-running sample tick divider (wraps at DB_DIV)
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == '0);

    sw_debounce #(
        .DB_LEN (DB_LEN)
    ) u_db_start (
        .clk0    (clk0),
        .reset_n (reset_n),
        .tick    (tick),
        .sw      (start_sw),
        .level   (start_lvl_unused),
        .press   (start_press)
    );

    sw_debounce #(
        .DB_LEN (DB_LEN)
    ) u_db_lap (
        .clk0    (clk0),
        .reset_n (reset_n),
        .tick    (tick),
        .sw      (lap_sw),
        .level   (lap_lvl),
        .press   (lap_press)
    );

    assign lp_fire = tick & lap_lvl & (st_q == STOP)
                   & (lp_cnt_q == 8'(LONG_TICKS - 1));

    // Count held lap ticks in STOP, saturating so a hold fires once
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            lp_cnt_q <= '0;
        end else if (!lap_lvl || st_q != STOP) begin
            lp_cnt_q <= '0;
        end else if (tick && lp_cnt_q != 8'(LONG_TICKS)) begin
            lp_cnt_q <= lp_cnt_q + 8'd1;
        end
    end

    // Main sequencer with sticky overflow and clear pulse
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            st_q  <= IDLE;
            ovf_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            unique case (st_q)
                IDLE: begin
                    if (start_press) begin
                        st_q <= RUN;
                    end
                end
                RUN: begin
                    if (ovf_in) begin
                        st_q  <= STOP;
                        ovf_q <= 1'b1;
                    end else if (start_press) begin
                        st_q <= STOP;
                    end else if (lap_press) begin
                        st_q <= LAP;
                    end
                end
                LAP: begin
                    if (ovf_in) begin
                        st_q  <= STOP;
                        ovf_q <= 1'b1;
                    end else if (start_press) begin
                        st_q <= STOP;
                    end else if (lap_press) begin
                        st_q <= RUN;
                    end
                end
                STOP: begin
                    if (start_press && !ovf_q) begin
                        st_q <= RUN;
                    end else if (lp_fire) begin
                        st_q  <= IDLE;
                        clr_q <= 1'b1;
                        ovf_q <= 1'b0;
                    end
                end
                default: begin
                    st_q <= IDLE;
                end
            endcase
        end
    end

    assign state  = st_q;
    assign run    = (st_q == RUN) || (st_q == LAP);
    assign freeze = (st_q == LAP);
    assign ovf    = ovf_q;
    assign clr    = clr_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the 4-digit stopwatch datapath (prescaler plus cascaded decade counters plus 7-seg mux).
- Debounces the start and lap buttons.
- Runs the run/stop/lap state machine.
- Drives the prescaler count enable, the synchronous counter clear and the display freeze.
- Stops and flags overflow when the top decade carries out.

Parameters:
DB_DIV, 1048576, clk0 cycles between debounce sample ticks (2^20, about 10.5 ms at 100 MHz); power of two >= 2.
DB_LEN, 5, number of consecutive equal samples required to change a debounced level (2..8).
LONG_TICKS, 100, sample ticks lap must be held in STOP to count as a long press (clear); range 1..255.

Ports:
clk0  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_sw  in  1  raw start/stop button, asynchronous, active-high
lap_sw  in  1  raw lap/clear button, asynchronous, active-high
ovf_in  in  1  carry out of the top decade counter, 1-cycle pulse, clk0 domain
run  out  1  prescaler count enable
clr  out  1  1-cycle synchronous clear to all counters
freeze  out  1  display latch hold (datapath keeps the last shown value while 1)
ovf  out  1  sticky overflow flag
state  out  2  FSM state code for LEDs/debug

Behaviour:
- Reset (reset_n=0, async):
  - FSM = IDLE; run=0, clr=0, freeze=0, ovf=0, state=2'b00.
  - Synchronizers, sample shift registers, debounced levels, tick divider and long-press counter all = 0.
- Input path, per button:
  - 2-flop synchronizer.
  - Sample into a DB_LEN-bit shift register on each sample tick; tick = divider at 0, divider is free-running modulo DB_DIV.
  - Debounced level goes 1 when all samples are 1 and goes 0 when all samples are 0; otherwise it holds (hysteresis).
  - press = debounced level AND NOT its 1-cycle-delayed copy; 1-cycle pulse.
- FSM (registered; transitions on the edge after the press pulse). Codes: IDLE=00, RUN=01, STOP=10, LAP=11.
  - IDLE: start press -> RUN. Lap is ignored.
  - RUN: ovf_in -> STOP and ovf<=1. Otherwise start press -> STOP; lap press -> LAP.
  - LAP (counting, display frozen): ovf_in -> STOP and ovf<=1. Otherwise start press -> STOP; lap press -> RUN.
  - STOP:
    - start press -> RUN only if ovf=0; ignored if ovf=1.
    - lap long press -> IDLE, clr=1 for exactly one cycle (the cycle after the transition edge), ovf<=0.
    - Short lap press (released before LONG_TICKS) has no effect.
- Priority within one cycle: ovf_in > start press > lap press.
- Outputs are Moore, decoded from registered state:
  - run=1 in RUN and LAP.
  - freeze=1 in LAP only.
  - clr is a registered pulse.
- Long-press counter (8-bit):
  - Cleared whenever lap's debounced level=0 or state!=STOP.
  - Increments on sample ticks while lap's debounced level=1 in STOP; saturates at LONG_TICKS.
  - Fires once at the tick where it reaches LONG_TICKS; the held button does not retrigger.
- A lap press that entered STOP via start does not start the long-press count until lap rises while already in STOP. The press edge pulse is ignored in STOP; only the level counts.
- Buttons held across reset deassertion do not generate a press: debounced levels reset to 0, so a press is generated only once the button is debounced high after reset.
- ovf_in is ignored in IDLE and STOP.

Decomposition:
- Package stopwatch_pkg:
  - state code constants IDLE/RUN/STOP/LAP;
  - default DB_DIV/DB_LEN values.
- One sub-module, sw_debounce (synchronizer, sample shift register, hysteresis, press pulse; parameter DB_LEN; tick input shared).
  - Instantiated twice.
  - The tick divider lives in stopwatch_ctrl.

Test Plan:
Bench parameters: DB_DIV=4, DB_LEN=3, LONG_TICKS=8.
1. Reset, then hold start_sw=1 for 40 cycles -> exactly one press; state 00->01, run=1, freeze=0; release -> no further change.
2. Glitchy start_sw (toggle every 3 cycles for 30 cycles, then low) -> debounced level never rises, state stays 00, run=0.
3. RUN, lap press -> state=11, freeze=1, run=1; lap press -> state=01, freeze=0; start press -> state=10, run=0.
4. RUN, pulse ovf_in one cycle -> next edge state=10, ovf=1, run=0; start press -> stays 10.
5. STOP with ovf=1, hold lap_sw 20 ticks -> at 8th held tick state=00, clr high exactly 1 cycle, ovf=0; continued hold -> no second clr; short lap hold (4 ticks) in STOP -> no change.
6. Start press and ovf_in in the same cycle in RUN -> STOP with ovf=1; assert reset_n=0 mid-RUN -> all outputs 0 immediately (async).
